// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared offsets, status bit indices and TX FSM encoding
package uart_mmio_pkg;

  localparam logic [31:0] STATUS_OFF = 32'h0;
  localparam logic [31:0] RXDATA_OFF = 32'h4;
  localparam logic [31:0] TXDATA_OFF = 32'h8;

  localparam int ST_TX_SPACE = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_DROP  = 3;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular TX byte queue with combinational head
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy for full/empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - CPU-facing UART window: RX holding reg, TX queue, sticky status
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h80000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  IO_trans,
  input  logic        IO_recv,
  output logic [31:0] Received,
  output logic [7:0]  UartDataIn,
  output logic        UartDataInValid,
  input  logic        UartDataInReady,
  input  logic [7:0]  UartDataOut,
  input  logic        UartDataOutValid,
  output logic        UartDataOutReady
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic            is_load;
  logic            is_store;
  logic            ld_status;
  logic            ld_rxdata;
  logic            st_txdata;
  logic            rx_valid;
  logic            rx_overrun;
  logic            tx_drop;
  logic [7:0]      rx_byte;
  logic [7:0]      tx_data;
  logic            rx_accept;
  logic            ovr_set;
  logic            drop_set;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   unused_fifo_count;
  logic            unused_bits;
  tx_state_e       state;
  tx_state_e       state_next;

  // A cycle with both strobes is ambiguous and is treated as no access.
  assign is_load   = IO_recv && !IO_trans[0];
  assign is_store  = IO_trans[0] && !IO_recv;
  assign ld_status = is_load  && (Addr == BASE_ADDR + STATUS_OFF);
  assign ld_rxdata = is_load  && (Addr == BASE_ADDR + RXDATA_OFF);
  assign st_txdata = is_store && (Addr == BASE_ADDR + TXDATA_OFF);

  // A load that drains the holding register frees it for a same-cycle byte.
  assign rx_accept = UartDataOutValid && (!rx_valid || ld_rxdata);
  assign ovr_set   = UartDataOutValid && rx_valid && !ld_rxdata;
  assign fifo_push = st_txdata && !fifo_full;
  assign drop_set  = st_txdata && fifo_full;

  assign UartDataOutReady = !Reset;
  assign UartDataInValid  = (state == TX_SEND) && !Reset;
  assign UartDataIn       = Reset ? 8'h00 : tx_data;
  assign unused_bits      = ^{WriteData[31:8], IO_trans[3:1]};

  // Load data mux; undecoded or disqualified accesses read as zero.
  always_comb begin
    Received = '0;
    if (ld_status) begin
      Received[ST_TX_SPACE] = !fifo_full;
      Received[ST_RX_VALID] = rx_valid;
      Received[ST_RX_OVR]   = rx_overrun;
      Received[ST_TX_DROP]  = tx_drop;
    end else if (ld_rxdata) begin
      Received = {24'h0, rx_byte};
    end
  end

  // RX holding register and sticky flags; a new event wins over a status-read clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_valid   <= 1'b0;
      rx_byte    <= 8'h00;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (rx_accept) begin
        rx_byte  <= UartDataOut;
        rx_valid <= 1'b1;
      end else if (ld_rxdata) begin
        rx_valid <= 1'b0;
      end
      if (ovr_set)        rx_overrun <= 1'b1;
      else if (ld_status) rx_overrun <= 1'b0;
      if (drop_set)       tx_drop <= 1'b1;
      else if (ld_status) tx_drop <= 1'b0;
    end
  end

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (fifo_push),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // Send FSM next state: pop only from idle, so every byte spends a cycle in idle.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (UartDataInReady) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Send FSM state and the byte register presented to the transmitter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= TX_IDLE;
      tx_data <= 8'h00;
    end else begin
      state <= state_next;
      if (fifo_pop) tx_data <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - directed and randomized checks against a queue-based model
module tb_uart_mmio_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  IO_trans;
  logic        IO_recv;
  logic [31:0] Received;
  logic [7:0]  UartDataIn;
  logic        UartDataInValid;
  logic        UartDataInReady;
  logic [7:0]  UartDataOut;
  logic        UartDataOutValid;
  logic        UartDataOutReady;

  int vecs = 0;
  int errs = 0;

  logic       m_rxv  = 1'b0;
  logic [7:0] m_rxb  = 8'h00;
  logic       m_ovr  = 1'b0;
  logic       m_drop = 1'b0;
  logic       m_send = 1'b0;
  logic [7:0] m_cur  = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] got[$];

  uart_mmio_ctrl #(.TX_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Addr             (Addr),
    .WriteData        (WriteData),
    .IO_trans         (IO_trans),
    .IO_recv          (IO_recv),
    .Received         (Received),
    .UartDataIn       (UartDataIn),
    .UartDataInValid  (UartDataInValid),
    .UartDataInReady  (UartDataInReady),
    .UartDataOut      (UartDataOut),
    .UartDataOutValid (UartDataOutValid),
    .UartDataOutReady (UartDataOutReady)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_load(input logic [31:0] a);
    return IO_recv && !IO_trans[0] && (Addr == a);
  endfunction

  function automatic logic [31:0] exp_received();
    logic [31:0] r;
    r = 32'h0;
    if (m_load(BASE))
      r = {28'h0, m_drop, m_ovr, m_rxv, 1'(m_q.size() < DEPTH)};
    else if (m_load(BASE + 32'h4))
      r = {24'h0, m_rxb};
    return r;
  endfunction

  task automatic sample();
    @(negedge Clock);
    chk("received", Received, exp_received());
    chk("tx_valid", 32'(UartDataInValid), 32'(m_send && !Reset));
    chk("tx_data",  32'(UartDataIn), 32'(Reset ? 8'h00 : m_cur));
    chk("rx_ready", 32'(UartDataOutReady), 32'(!Reset));
  endtask

  task automatic tick();
    logic ld_st, ld_rx, st_tx, full_pre, ovr_ev, drop_ev;
    ld_st    = m_load(BASE);
    ld_rx    = m_load(BASE + 32'h4);
    st_tx    = IO_trans[0] && !IO_recv && (Addr == BASE + 32'h8);
    full_pre = (m_q.size() == DEPTH);
    ovr_ev   = 1'b0;
    drop_ev  = 1'b0;
    @(posedge Clock);
    #1;
    if (Reset) begin
      m_rxv = 1'b0; m_rxb = 8'h00; m_ovr = 1'b0; m_drop = 1'b0;
      m_q.delete(); m_send = 1'b0; m_cur = 8'h00;
    end else begin
      if (m_send) begin
        if (UartDataInReady) m_send = 1'b0;
      end else if (m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_send = 1'b1;
      end
      if (st_tx) begin
        if (full_pre) drop_ev = 1'b1;
        else m_q.push_back(WriteData[7:0]);
      end
      if (UartDataOutValid) begin
        if (!m_rxv || ld_rx) begin
          m_rxb = UartDataOut;
          m_rxv = 1'b1;
        end else begin
          ovr_ev = 1'b1;
        end
      end else if (ld_rx) begin
        m_rxv = 1'b0;
      end
      if (ovr_ev) m_ovr = 1'b1;
      else if (ld_st) m_ovr = 1'b0;
      if (drop_ev) m_drop = 1'b1;
      else if (ld_st) m_drop = 1'b0;
    end
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic set_idle();
    IO_recv = 1'b0; IO_trans = 4'h0; Addr = 32'h0; WriteData = 32'h0;
    UartDataOutValid = 1'b0; UartDataOut = 8'h00;
  endtask

  task automatic do_load(input logic [31:0] a);
    set_idle();
    IO_recv = 1'b1; Addr = a;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [7:0] d);
    set_idle();
    IO_trans = 4'b0001; Addr = a; WriteData = {24'hC0FFEE, d};
  endtask

  initial begin
    Reset = 1'b1;
    UartDataInReady = 1'b0;
    set_idle();
    cyc();
    cyc();
    Reset = 1'b0;

    do_load(BASE);
    sample();
    chk("rst_status", Received, 32'h1);
    chk("rst_valid", 32'(UartDataInValid), 32'h0);
    chk("rst_ready", 32'(UartDataOutReady), 32'h1);
    tick();

    do_store(BASE + 32'h8, 8'h41);
    cyc();
    set_idle();
    cyc();
    sample();
    chk("tx41_data", 32'(UartDataIn), 32'h41);
    chk("tx41_valid", 32'(UartDataInValid), 32'h1);
    tick();
    cyc();
    UartDataInReady = 1'b1;
    cyc();
    UartDataInReady = 1'b0;
    sample();
    chk("tx41_done", 32'(UartDataInValid), 32'h0);
    tick();
    do_load(BASE);
    sample();
    chk("tx41_status", Received, 32'h1);
    tick();

    for (int i = 1; i <= 6; i++) begin
      do_store(BASE + 32'h8, 8'(i));
      cyc();
    end
    do_load(BASE);
    sample();
    chk("drop_status", Received, 32'h8);
    tick();
    sample();
    chk("drop_cleared", Received, 32'h0);
    tick();
    set_idle();
    UartDataInReady = 1'b1;
    got.delete();
    for (int i = 0; i < 14; i++) begin
      sample();
      if (UartDataInValid && UartDataInReady) got.push_back(UartDataIn);
      tick();
    end
    chk("order_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) chk("order_byte", 32'(got[i]), 32'(i + 1));

    UartDataInReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_store(BASE + 32'h8, 8'(8'h10 + i));
      cyc();
    end
    set_idle();
    UartDataOutValid = 1'b1; UartDataOut = 8'h5A;
    cyc();
    UartDataOut = 8'hA5;
    cyc();
    do_load(BASE);
    sample();
    chk("ovr_status", Received, 32'h6);
    tick();
    do_load(BASE + 32'h4);
    sample();
    chk("ovr_rxdata", Received, 32'h5A);
    tick();
    do_load(BASE);
    sample();
    chk("ovr_cleared", Received, 32'h0);
    tick();

    set_idle();
    UartDataOutValid = 1'b1; UartDataOut = 8'h77;
    cyc();
    do_load(BASE + 32'h4);
    UartDataOutValid = 1'b1; UartDataOut = 8'h33;
    sample();
    chk("same_cyc_old", Received, 32'h77);
    tick();
    do_load(BASE);
    sample();
    chk("same_cyc_status", Received, 32'h2);
    tick();
    do_load(BASE + 32'h4);
    sample();
    chk("same_cyc_new", Received, 32'h33);
    tick();

    set_idle();
    UartDataInReady = 1'b1;
    repeat (12) cyc();
    UartDataInReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_store(BASE + 32'h8, 8'(8'hB0 + i));
      cyc();
    end
    set_idle();
    cyc();
    Reset = 1'b1;
    sample();
    chk("mid_rst_valid", 32'(UartDataInValid), 32'h0);
    tick();
    Reset = 1'b0;
    do_load(BASE);
    sample();
    chk("post_rst_valid", 32'(UartDataInValid), 32'h0);
    chk("post_rst_status", Received, 32'h1);
    tick();
    set_idle();
    UartDataInReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("post_rst_quiet", 32'(UartDataInValid), 32'h0);
      tick();
    end

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 5))
        0: Addr = BASE;
        1: Addr = BASE + 32'h4;
        2, 3: Addr = BASE + 32'h8;
        4: Addr = BASE + 32'hC;
        default: Addr = $urandom;
      endcase
      Reset            = ($urandom_range(0, 63) == 0);
      IO_recv          = ($urandom_range(0, 2) == 0);
      IO_trans         = 4'($urandom);
      WriteData        = $urandom;
      UartDataInReady  = 1'($urandom_range(0, 1));
      UartDataOutValid = ($urandom_range(0, 3) == 0);
      UartDataOut      = 8'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller that sits between the CPU memory stage and the UART core. It decodes the UART I/O window and owns every UART handshake:
- RX: a single-byte holding register with overrun detection.
- TX: a small FIFO drained by a send state machine.
- Status: sticky error flags readable and clearable by software.

The CPU sees single-cycle, side-effect-exact loads and stores. The UART sees clean valid/ready transfers.

Parameters:
TX_DEPTH, 4, TX FIFO entries (power of two, >=2)
BASE_ADDR, 32'h80000000, base of the UART I/O window

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Addr  in  32  CPU load/store address
WriteData  in  32  CPU store data (rd2)
IO_trans  in  4  store byte enables; bit0 qualifies a UART store
IO_recv  in  1  load strobe for the I/O window
Received  out  32  load data (combinational from registers)
UartDataIn  out  8  byte to UART transmitter
UartDataInValid  out  1  TX valid
UartDataInReady  in  1  TX ready
UartDataOut  in  8  byte from UART receiver
UartDataOutValid  in  1  RX valid
UartDataOutReady  out  1  RX ready; constant 1 outside reset

Behaviour:
- Register map:
  - BASE+0 status (read): bit0 tx_space (FIFO not full), bit1 rx_valid, bit2 rx_overrun, bit3 tx_drop, bits 31:4 = 0.
  - BASE+4 rx data (read): {24'b0, rx_byte}.
  - BASE+8 tx data (write): WriteData[7:0].
- Decode: exact 32-bit match. Any other address gives Received = 0 and no side effects.
- Access qualification:
  - Load = IO_recv && !IO_trans[0].
  - Store = IO_trans[0] && !IO_recv.
  - Both asserted: neither load nor store; Received = 0.
  - A load to BASE+8 or a store to BASE+0/+4 returns 0 and has no effect.
- Received is combinational. All side effects commit at the rising Clock edge ending the access cycle.
- Reset (sync, active-high):
  - rx_valid=0, rx_byte=0, rx_overrun=0, tx_drop=0.
  - FIFO empty; TX FSM in TX_IDLE.
  - UartDataInValid=0, UartDataIn=0, UartDataOutReady=0 during the Reset cycle.
  - Asserting reset mid-transfer abandons the current byte and any queued bytes; UartDataInValid is low the cycle after the reset edge.
- RX path:
  - UartDataOutReady=1 whenever not in reset.
  - On an edge with UartDataOutValid=1:
    - If rx_valid=0, or a BASE+4 load occurs the same cycle: rx_byte <= UartDataOut, rx_valid <= 1.
    - Else: byte dropped, rx_byte unchanged, rx_overrun <= 1 (sticky).
  - BASE+4 load with no incoming byte: returns rx_byte and clears rx_valid. A load while rx_valid=0 returns the stale rx_byte.
- Status load: returns current flags, then clears rx_overrun and tx_drop at the edge. A flag set by an event in the same cycle as the read stays set (set wins over clear).
- TX FIFO:
  - Circular buffer with log2(TX_DEPTH)-bit pointers plus a count of log2(TX_DEPTH)+1 bits. Pointers wrap modulo TX_DEPTH.
  - BASE+8 store when count<TX_DEPTH: push. Store when count==TX_DEPTH: dropped and tx_drop <= 1. Fullness is judged before a same-cycle pop, so a pop does not rescue the store.
  - Push and pop in the same cycle is legal; count is unchanged.
- TX FSM (two states):
  - TX_IDLE: if count>0, pop the head into the UartDataIn register and go to TX_SEND. UartDataInValid=0.
  - TX_SEND: UartDataInValid=1, UartDataIn held stable. When UartDataInReady=1 at an edge, go to TX_IDLE.
  - No back-to-back sends: every byte costs at least 2 cycles plus UART ready time.
  - Latency: a store at edge N makes the byte visible on UartDataIn with UartDataInValid=1 from edge N+1.

Decomposition:
- Package uart_mmio_pkg:
  - Address offsets (STATUS_OFF=0, RXDATA_OFF=4, TXDATA_OFF=8).
  - Status bit indices (ST_TX_SPACE=0, ST_RX_VALID=1, ST_RX_OVR=2, ST_TX_DROP=3).
  - TX FSM encoding (TX_IDLE=1'b0, TX_SEND=1'b1).
- Sub-module uart_tx_fifo (params WIDTH=8, DEPTH):
  - Ports Clock, Reset, push, din, pop, dout, full, empty, count.
  - dout shows the head combinationally.
- RX holding register, status flags, decode and FSM stay in the top module.

Test Plan:
- Reset, then status load -> Received=32'h1. UartDataInValid=0, UartDataOutReady=1 the cycle after reset.
- Store 8'h41 to 80000008 with UartDataInReady held 0 for 3 cycles, then 1 -> UartDataIn=8'h41 and UartDataInValid=1 from next edge until the ready edge. Valid then drops and the FIFO is empty.
- Five stores (8'h01..8'h05) in consecutive cycles with UartDataInReady=0, TX_DEPTH=4:
  - First pop in cycle 2 lets 8'h05 be accepted; a sixth store is dropped.
  - tx_drop=1 (status=32'h8); the status read clears it.
  - Bytes then emerge in order 01..05.
- UART delivers 8'h5A then 8'hA5 with no CPU read -> status=32'h6. BASE+4 load returns 32'h5A. The next status read returns 32'h0 (overrun cleared by the previous read).
- BASE+4 load in the same cycle UART delivers 8'h33 while rx_valid=1 -> load returns the old byte. rx_byte becomes 8'h33, rx_valid stays 1, no overrun.
- Reset asserted while in TX_SEND with 2 bytes queued -> UartDataInValid=0 next cycle, status=32'h1, no further bytes sent.
